// File: rtl/cs_pkg.sv
// Shared types and helpers for the cyclic-shift (K, K+1) erasure decoder:
// FSM encoding, variable-amount rotate and the legal-K check.
package cs_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_EMIT    = 2'd2
    } cs_state_t;

    localparam int ROT_MAX_W    = 64;
    localparam int ROT_IDX_W    = 6;
    localparam int K_MIN        = 2;
    localparam int K_MAX_MARGIN = 1;

    function automatic bit k_is_legal(input int k, input int w);
        return (k >= K_MIN) && (k <= w - K_MAX_MARGIN) && (w <= ROT_MAX_W);
    endfunction

    // Rotate the low w bits of x toward the MSB by n mod w; bits above w read as 0.
    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                  input int n, input int w);
        logic [ROT_MAX_W-1:0] y;
        int                   s;
        y = '0;
        s = n % w;
        for (int b = 0; b < ROT_MAX_W; b++) begin
            if (b < w) begin
                y[ROT_IDX_W'((b + s) % w)] = x[ROT_IDX_W'(b)];
            end else begin
                y[ROT_IDX_W'(b)] = 1'b0;
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/cs_var_rotate.sv
// Combinational cyclic rotator: o_y = rotl(i_x, i_amt) over WIDTH bits.
module cs_var_rotate
    import cs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [AMT_W-1:0] i_amt,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = WIDTH'(rotl(ROT_MAX_W'(i_x), int'(i_amt), WIDTH));

endmodule

// File: rtl/cs_stream_decoder.sv
// Streaming (K, K+1) cyclic-shift erasure decoder: buffers one codeword,
// repairs a single erased data symbol, then emits the K data symbols.
module cs_stream_decoder
    import cs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int K     = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sym,
    input  logic                 in_erased,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sym,
    output logic [$clog2(K)-1:0] out_idx,
    output logic                 out_last,
    output logic                 out_ok,
    output logic [CNT_W-1:0]     recov_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    localparam int IDX_W  = $clog2(K + 1);
    localparam int OIDX_W = $clog2(K);
    localparam int AMT_W  = $clog2(WIDTH) + 1;

    if (!k_is_legal(K, WIDTH)) begin : g_bad_k
        $error("cs_stream_decoder: K must lie in 2..WIDTH-1");
    end

    cs_state_t          r_state;
    cs_state_t          w_state_nxt;
    logic [IDX_W-1:0]   r_in_cnt;
    logic [1:0]         r_era_cnt;
    logic [IDX_W-1:0]   r_era_idx;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_res_acc;
    logic [1:0]         r_res_era;
    logic [IDX_W-1:0]   r_res_idx;
    logic [WIDTH-1:0]   r_buf [K];
    logic               r_ok;
    logic [OIDX_W-1:0]  r_out_idx;
    logic [CNT_W-1:0]   r_recov_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_is_par;
    logic [OIDX_W-1:0]  w_wr_idx;
    logic [OIDX_W-1:0]  w_rec_idx;
    logic [AMT_W-1:0]   w_in_amt;
    logic [AMT_W-1:0]   w_rec_amt;
    logic [WIDTH-1:0]   w_rot_in;
    logic [WIDTH-1:0]   w_rot_rec;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [1:0]         w_era_nxt;
    logic [IDX_W-1:0]   w_era_idx_nxt;

    assign w_in_fire  = in_valid && (r_state == ST_COLLECT);
    assign w_out_fire = out_valid && out_ready;
    assign w_is_par   = (r_in_cnt == IDX_W'(K));
    assign w_wr_idx   = r_in_cnt[OIDX_W-1:0];
    assign w_rec_idx  = r_res_idx[OIDX_W-1:0];
    assign w_in_amt   = AMT_W'(r_in_cnt) + AMT_W'(1);
    // Undo the encoder's rotl(d_j, j+1) by rotating the rest the remaining way round.
    assign w_rec_amt  = AMT_W'(WIDTH) - AMT_W'(r_res_idx) - AMT_W'(1);

    cs_var_rotate #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_rot_acc (
        .i_x   (in_sym),
        .i_amt (w_in_amt),
        .o_y   (w_rot_in)
    );

    cs_var_rotate #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_rot_rec (
        .i_x   (r_res_acc),
        .i_amt (w_rec_amt),
        .o_y   (w_rot_rec)
    );

    assign in_ready  = (r_state == ST_COLLECT);
    assign out_valid = (r_state == ST_EMIT);
    assign out_sym   = r_buf[r_out_idx];
    assign out_idx   = r_out_idx;
    assign out_last  = out_valid && (r_out_idx == OIDX_W'(K - 1));
    assign out_ok    = r_ok;
    assign recov_cnt = r_recov_cnt;
    assign fail_cnt  = r_fail_cnt;

    // Accumulator and erasure bookkeeping after the symbol currently offered.
    always_comb begin
        w_acc_nxt     = r_acc;
        w_era_nxt     = r_era_cnt;
        w_era_idx_nxt = r_era_idx;
        if (in_erased) begin
            w_era_idx_nxt = r_in_cnt;
            if (r_era_cnt != 2'd2) begin
                w_era_nxt = r_era_cnt + 2'd1;
            end else begin
                w_era_nxt = r_era_cnt;
            end
        end else if (w_is_par) begin
            w_acc_nxt = r_acc ^ in_sym;
        end else begin
            w_acc_nxt = r_acc ^ w_rot_in;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (w_in_fire && w_is_par) begin
                    w_state_nxt = ST_RESOLVE;
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_RESOLVE: w_state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (w_out_fire && out_last) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: collect, repair, emit and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_cnt    <= '0;
            r_era_cnt   <= 2'd0;
            r_era_idx   <= '0;
            r_acc       <= '0;
            r_res_acc   <= '0;
            r_res_era   <= 2'd0;
            r_res_idx   <= '0;
            r_ok        <= 1'b0;
            r_out_idx   <= '0;
            r_recov_cnt <= '0;
            r_fail_cnt  <= '0;
            for (int i = 0; i < K; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_in_fire && w_is_par) begin
                        // Hand the final totals to RESOLVE and start the next codeword clean.
                        r_res_acc <= w_acc_nxt;
                        r_res_era <= w_era_nxt;
                        r_res_idx <= w_era_idx_nxt;
                        r_acc     <= '0;
                        r_in_cnt  <= '0;
                        r_era_cnt <= 2'd0;
                    end else if (w_in_fire) begin
                        r_acc             <= w_acc_nxt;
                        r_era_cnt         <= w_era_nxt;
                        r_era_idx         <= w_era_idx_nxt;
                        r_in_cnt          <= r_in_cnt + IDX_W'(1);
                        r_buf[w_wr_idx]   <= in_erased ? '0 : in_sym;
                    end
                end
                ST_RESOLVE: begin
                    r_out_idx <= '0;
                    if ((r_res_era == 2'd0) ||
                        ((r_res_era == 2'd1) && (r_res_idx == IDX_W'(K)))) begin
                        r_ok <= 1'b1;
                    end else if (r_res_era == 2'd1) begin
                        r_buf[w_rec_idx] <= w_rot_rec;
                        r_ok             <= 1'b1;
                        if (r_recov_cnt != '1) r_recov_cnt <= r_recov_cnt + CNT_W'(1);
                    end else begin
                        r_ok <= 1'b0;
                        for (int i = 0; i < K; i++) r_buf[i] <= '0;
                        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (w_out_fire && out_last) begin
                        r_out_idx <= '0;
                    end else if (w_out_fire) begin
                        r_out_idx <= r_out_idx + OIDX_W'(1);
                    end
                end
                default: r_out_idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_stream_decoder.sv
// Scoreboard bench for cs_stream_decoder: directed vectors plus randomized
// codewords checked against an arithmetic model of the erasure code.
module tb_cs_stream_decoder;

    localparam int W  = 4;
    localparam int K  = 3;
    localparam int CW = 16;
    localparam int IW = $clog2(K);

    typedef struct {
        int sym;
        int idx;
        int last;
        int ok;
        int recov;
        int fail;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sym;
    logic          in_erased;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sym;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_ok;
    logic [CW-1:0] recov_cnt;
    logic [CW-1:0] fail_cnt;

    int   checks    = 0;
    int   errors    = 0;
    int   exp_recov = 0;
    int   exp_fail  = 0;
    exp_t sb[$];

    cs_stream_decoder #(.WIDTH(W), .K(K), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_erased (in_erased),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ok    (out_ok),
        .recov_cnt (recov_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ref_rotl(input int x, input int n);
        int s;
        int mask;
        s    = n % W;
        mask = (1 << W) - 1;
        if (s == 0) return x & mask;
        return ((x << s) | (x >> (W - s))) & mask;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sym",   out_sym,   0);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_ok",    out_ok,    0);
        chk("rst_recov_cnt", recov_cnt, 0);
        chk("rst_fail_cnt",  fail_cnt,  0);
    endtask

    task automatic put_sym(input int s, input bit e, input int gap);
        bit got;
        repeat (gap) step();
        in_valid  = 1'b1;
        in_sym    = W'(s);
        in_erased = e;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        chk("in_accept", got, 1);
        in_valid  = 1'b0;
        in_erased = 1'b0;
        in_sym    = '0;
    endtask

    // Model: any single erasure is repairable (MDS); two or more zero the block.
    task automatic send_cw(input int d[K], input bit [K:0] er, input bit rnd);
        int   par;
        int   nera;
        int   s;
        exp_t e;
        par = 0;
        for (int i = 0; i < K; i++) par ^= ref_rotl(d[i], i + 1);
        nera = $countones(er);
        if (nera == 1 && !er[K]) exp_recov++;
        if (nera >= 2) exp_fail++;
        for (int i = 0; i < K; i++) begin
            e.sym   = (nera <= 1) ? d[i] : 0;
            e.idx   = i;
            e.last  = (i == K - 1) ? 1 : 0;
            e.ok    = (nera <= 1) ? 1 : 0;
            e.recov = exp_recov;
            e.fail  = exp_fail;
            sb.push_back(e);
        end
        for (int i = 0; i <= K; i++) begin
            s = (i < K) ? d[i] : par;
            if (er[i]) s = rnd ? int'($urandom_range(0, (1 << W) - 1)) : (1 << W) - 1;
            put_sym(s, er[i], rnd ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic drain(input int p_low);
        int n;
        n = 0;
        for (int c = 0; c < 200 && n < K; c++) begin
            out_ready = ($urandom_range(0, 99) >= p_low);
            @(negedge clk);
            if (out_valid && out_ready) n++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        chk("drain_count", n, K);
    endtask

    initial begin : monitor
        exp_t         e;
        bit           stall;
        logic [W-1:0] p_sym;
        int           p_idx;
        bit           p_last;
        bit           p_ok;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                chk("emit_in_ready_low", in_ready, 0);
                if (stall) begin
                    chk("stall_sym",  out_sym,  p_sym);
                    chk("stall_idx",  out_idx,  p_idx);
                    chk("stall_last", out_last, p_last);
                    chk("stall_ok",   out_ok,   p_ok);
                end
                if (out_ready) begin
                    stall = 1'b0;
                    chk("sb_has_entry", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_sym",   out_sym,   e.sym);
                        chk("out_idx",   out_idx,   e.idx);
                        chk("out_last",  out_last,  e.last);
                        chk("out_ok",    out_ok,    e.ok);
                        chk("recov_cnt", recov_cnt, e.recov);
                        chk("fail_cnt",  fail_cnt,  e.fail);
                    end
                end else begin
                    stall  = 1'b1;
                    p_sym  = out_sym;
                    p_idx  = out_idx;
                    p_last = out_last;
                    p_ok   = out_ok;
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int       d[K];
        bit [K:0] er;
        int       r;
        bit       got;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sym    = '0;
        in_erased = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk_reset();
        rst_n = 1'b1;
        step();

        d = '{1, 2, 4};
        send_cw(d, 4'b0000, 1'b0); drain(0);
        send_cw(d, 4'b0010, 1'b0); drain(20);
        send_cw(d, 4'b0001, 1'b0); drain(20);
        send_cw(d, 4'b1000, 1'b0); drain(0);
        send_cw(d, 4'b1001, 1'b0); drain(20);
        send_cw(d, 4'b0000, 1'b0); drain(0);

        // Backpressure: hold idx 1 for five cycles.
        send_cw(d, 4'b0000, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("bp_first_valid", got, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_sym",   out_sym,  2);
            chk("bp_hold_idx",   out_idx,  1);
            chk("bp_hold_inrdy", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_last_flag", out_last, 1);
        chk("bp_last_idx",  out_idx,  2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_valid_drop",    out_valid, 0);
        step();

        // Reset in the middle of a codeword.
        put_sym(1, 1'b0, 0);
        put_sym(2, 1'b0, 0);
        rst_n = 1'b0;
        step();
        chk_reset();
        rst_n     = 1'b1;
        exp_recov = 0;
        exp_fail  = 0;
        step();
        send_cw(d, 4'b0001, 1'b0); drain(0);

        for (int cw = 0; cw < 40; cw++) begin
            for (int i = 0; i < K; i++) d[i] = int'($urandom_range(0, (1 << W) - 1));
            r  = int'($urandom_range(0, 9));
            er = '0;
            if (r >= 3 && r <= 6) begin
                er[$urandom_range(0, K)] = 1'b1;
            end else if (r >= 7) begin
                while ($countones(er) < 2) er = (K+1)'($urandom_range(0, (1 << (K + 1)) - 1));
            end
            send_cw(d, er, 1'b1);
            drain(25);
        end

        repeat (5) step();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cs_stream_decoder.md
# cs_stream_decoder

Streaming, parametrised (K, K+1) cyclic-shift MDS erasure decoder, successor to the fixed (2,3) decoder. Accepts one coded symbol per handshake. Buffers a whole codeword, repairs any single erased symbol with a variable-amount cyclic rotate plus XOR, then emits the K data symbols serially with a decode-status flag. Sits between the link-side erasure detector and the data sink. Both sides use valid/ready.

## Interface
- WIDTH, 4: symbol width in bits (L-1).
- K, 3: data symbols per codeword. Legal range is 2..WIDTH-1. Parity is symbol index K.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  coded symbol present.
- in_ready  out  1  decoder accepts the symbol.
- in_sym  in  WIDTH  coded symbol. Order within a codeword is data_0..data_{K-1}, then parity.
- in_erased  in  1  symbol lost. in_sym is ignored when this is 1.
- out_valid  out  1  data symbol present.
- out_ready  in  1  sink accepts the symbol.
- out_sym  out  WIDTH  recovered data symbol.
- out_idx  out  $clog2(K)  data index, 0..K-1.
- out_last  out  1  out_idx == K-1.
- out_ok  out  1  codeword decoded. 0 means more than one erasure.
- recov_cnt  out  CNT_W  codewords that needed data recovery. Saturating.
- fail_cnt  out  CNT_W  undecodable codewords. Saturating.

## Operation
- Encoding convention: parity = XOR over i of rotl(d_i, i+1). rotl(x,n) rotates toward the MSB by n mod WIDTH.
- FSM states: COLLECT, RESOLVE, EMIT.
- COLLECT behaviour:
  - in_ready = 1. An input symbol is accepted on in_valid && in_ready.
  - The input counter counts 0..K and is the symbol's index.
  - Data symbol i, not erased: buf[i] <= in_sym and acc ^= rotl(in_sym, i+1).
  - Parity, not erased: acc ^= in_sym.
  - Erased symbol: buf[i] <= 0. The erasure counter increments, saturating at 2, and era_idx <= i.
  - When index K is accepted, go to RESOLVE. acc and the counters are cleared on that transition, so the next codeword starts clean.
- RESOLVE takes 1 cycle with in_ready = 0. The decision uses the final erasure count, including the last symbol.
  - 0 erasures, or only parity erased: ok = 1. Buffer is unchanged.
  - 1 data erasure at j: buf[j] <= rotl(acc, WIDTH-(j+1)) and ok = 1. recov_cnt increments.
  - 2 or more erasures: ok = 0. All buf entries are forced to 0. fail_cnt increments.
  - Always go to EMIT.
- EMIT behaviour:
  - out_valid = 1 and out_sym = buf[out_idx]. out_ok holds the codeword's ok for all K symbols.
  - out_idx advances on out_valid && out_ready.
  - On the handshake with out_last, go to COLLECT.
- Only one codeword is in flight. Input and output handshakes are never active in the same cycle.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_sym = 0, out_idx = 0, out_last = 0, out_ok = 0, recov_cnt = 0, fail_cnt = 0. FSM = COLLECT. acc and buf are 0.
- Reset asserted mid-codeword (COLLECT or EMIT) discards the partial codeword. No output follows for it.
- Latency: last input accepted in cycle t, RESOLVE in t+1, first out_valid in t+2.
- Minimum cycles per codeword, with no stalls: 2K+2.
- Backpressure: while out_valid && !out_ready, out_sym, out_idx, out_last and out_ok stay stable.
- in_valid gaps during COLLECT are allowed. The counters hold.
- All outputs are registered or decoded directly from registered state. There is no combinational path from in_* or out_ready to outputs.
- Counters saturate at 2^CNT_W-1. They do not wrap.

## Structure
- Package cs_pkg holds:
  - the FSM state enum;
  - the function rotl(x, n) with a variable n;
  - a constant for the legal-K check (elaboration assertion K <= WIDTH-1).
- Sub-module cs_var_rotate: a combinational variable-amount cyclic rotator with parameter WIDTH.
  - One instance is used for the accumulate path, with amount i+1.
  - One instance is used for the recovery path, with amount WIDTH-(j+1).

## Test plan
Defaults WIDTH=4, K=3, with d = {0001, 0010, 0100}, so parity = 1000.

- No erasure, symbols 0001, 0010, 0100, 1000 → outputs 0001, 0010, 0100 with out_ok = 1. recov_cnt and fail_cnt stay 0.
- d1 erased (in_sym = 1111 garbage) → out_sym[1] = 0010 and out_ok = 1. recov_cnt = 1.
- d0 erased → out_sym[0] = 0001 and out_ok = 1. Parity erased → pass-through, recov_cnt unchanged.
- d0 and parity erased → three outputs of 0000 with out_ok = 0. fail_cnt = 1. The next clean codeword decodes with out_ok = 1.
- out_ready held low for 5 cycles on idx 1 → out_sym stays 0010 and in_ready stays 0. After release, out_last pulses on idx 2 and in_ready returns to 1 the next cycle.
- rst_n low for 1 cycle after 2 input symbols → all outputs at reset values. A following full codeword decodes correctly, with no stale buffer or acc contents.
